dcache_ram_responder: RTL and testbench
=======================================

Name: dcache_ram_responder

Overview:
- Memory-side responder for the data cache's RAM request interface.
- Services three request types: uncached single-word reads, cached 16-word line refills, and byte-strobed single-word write-throughs.
- Backed by an internal word-addressed memory array.
- Serves as the data RAM model in system simulation and as the endpoint in front of the future AXI bridge.

Parameters:
- MEM_ADDR_WIDTH, 14, word-address width of the internal array (2^14 words = 64KB).
- OFFSET_WIDTH, 6, line offset bits; burst length = 2^(OFFSET_WIDTH-2) = 16 beats.
- READ_LATENCY, 2, cycles from the addr_ok cycle to the first read beat; must be >=1.
- WRITE_LATENCY, 1, cycles from the addr_ok cycle to write data_ok; must be >=1.
- INIT_FILE, "", hex file loaded into the array at time zero when non-empty.

Ports:
- ram_clk  in  1  clock.
- ram_rst  in  1  synchronous reset, active-high.
- ram_req  in  4  byte strobe; nonzero means a request is present.
- ram_wr  in  1  1 = write, 0 = read.
- uncached  in  1  with a read: 1 = single word, 0 = line burst.
- ram_addr  in  32  byte address.
- ram_wdata  in  32  write data.
- ram_addr_ok  out  1  one-cycle pulse: request accepted.
- ram_beat_ok  out  1  ram_rdata is valid this cycle.
- ram_data_ok  out  1  one-cycle pulse: last beat / write complete.
- ram_rdata  out  32  read data; zero when ram_beat_ok=0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; counters 0. Array contents are not cleared.
- Reset mid-operation aborts the transaction: no further beats, and a pending write is discarded.
- Address mapping: word index = ram_addr[MEM_ADDR_WIDTH+1:2]. Upper bits are dropped, so 0xA000_0400 and 0x0000_0400 alias.
- FSM states: IDLE, WAIT, RBURST, RSINGLE, WRITE, TURN.
- IDLE: on a clock edge with ram_req!=0, latch addr, wr, uncached, strobe and wdata, then go to WAIT. Input changes after latching are ignored.
- For bursts the latched word index has its low OFFSET_WIDTH-2 bits forced to 0.
- WAIT: ram_addr_ok=1 in the first WAIT cycle only, then a latency counter runs.
  - Read: after READ_LATENCY cycles (counted from the addr_ok cycle) go to RBURST or RSINGLE.
  - Write: after WRITE_LATENCY cycles go to WRITE.
  - With latency=1 the next state's cycle immediately follows the addr_ok cycle.
- RBURST: one beat per cycle, no gaps.
  - Beat k (k=0..15): ram_beat_ok=1, ram_rdata=mem[base+k].
  - On beat 15, ram_data_ok=1 as well; go to TURN.
  - The beat counter is 4 bits and must not wrap into a 17th beat.
- RSINGLE: one cycle with ram_beat_ok=1, ram_data_ok=1, ram_rdata=mem[word]; go to TURN.
- WRITE: one cycle with ram_data_ok=1.
  - For each strobe bit i set, mem[word] byte i = wdata[8i+7:8i]; unstrobed bytes are unchanged.
  - Memory commits at the edge ending this cycle; go to TURN.
- TURN: one idle cycle with all outputs 0. ram_req is ignored here because the cache drops it combinationally on data_ok. Go to IDLE.
- Minimum spacing: the next request is sampled no earlier than the second cycle after data_ok.
- Read-after-write: a read accepted after a write's data_ok returns the written data.
- Outputs are driven from state/registers only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: hold ram_rst 3 cycles with ram_req=4'hF -> all outputs 0 throughout. Assert addr_ok 1 cycle after release only if ram_req is still set.
- Uncached read: mem[0x100]=0xDEADBEEF; request ram_req=F, wr=0, uncached=1, addr=0xA000_0400 -> addr_ok in cycle A; beat_ok, data_ok and rdata=0xDEADBEEF in cycle A+2; then 1 TURN cycle.
- Burst refill: mem[0x110+k]=k*0x01010101; request addr=0x0000_0448, uncached=0 -> 16 consecutive beats from A+2, rdata 0x00000000..0x0F0F0F0F; data_ok only on beat 15.
- Strobed write: mem[0x20]=0x11223344; write addr=0x80, strobe=4'b0110, wdata=0xAABBCCDD -> data_ok at A+1. A subsequent single read returns 0x11BBCC44.
- Reset mid-burst: assert ram_rst during beat 5 -> next cycle beat_ok=0 and no data_ok. A new burst after reset starts again at beat 0.
- Input change during service: change ram_addr and ram_wr after addr_ok -> response still matches the latched request; no request is sampled during TURN.

Source files
------------

// File: rtl/dcache_ram_responder_if.sv
// Cache-to-RAM request/response bundle shared by the data cache and its RAM responder.
// Latency: none (wires only).
// Backpressure: none; the responder paces the cache with addr_ok / beat_ok / data_ok.
//   master = cache side (drives the request), slave = RAM side (drives the response).
interface dcache_ram_responder_if;
    logic [3:0]  ram_req;      // byte strobe, nonzero = request present
    logic        ram_wr;       // 1 = write, 0 = read
    logic        uncached;     // read only: 1 = single word, 0 = line burst
    logic [31:0] ram_addr;     // byte address
    logic [31:0] ram_wdata;    // write data
    logic        ram_addr_ok;  // one-cycle pulse: request accepted
    logic        ram_beat_ok;  // ram_rdata valid this cycle
    logic        ram_data_ok;  // one-cycle pulse: last beat / write complete
    logic [31:0] ram_rdata;    // read data, zero when no beat

    modport master (
        output ram_req, ram_wr, uncached, ram_addr, ram_wdata,
        input  ram_addr_ok, ram_beat_ok, ram_data_ok, ram_rdata
    );

    modport slave (
        input  ram_req, ram_wr, uncached, ram_addr, ram_wdata,
        output ram_addr_ok, ram_beat_ok, ram_data_ok, ram_rdata
    );
endinterface

// File: rtl/dcache_ram_responder.sv
// Memory-side responder for the data cache: uncached word reads, 16-beat line refills, strobed writes.
// Latency: addr_ok one cycle after the request is sampled; first read beat READ_LATENCY, write data_ok WRITE_LATENCY cycles after addr_ok.
// Backpressure: none accepted; one request in flight, next request sampled no earlier than two cycles after data_ok.
//   Ports: ram_clk / ram_rst (sync, active-high) plus the slave side of dcache_ram_responder_if.
//   Outputs decode only from state and latched registers; there is no input-to-output path.
module dcache_ram_responder #(
    parameter int    MEM_ADDR_WIDTH = 14,
    parameter int    OFFSET_WIDTH   = 6,
    parameter int    READ_LATENCY   = 2,
    parameter int    WRITE_LATENCY  = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic                   ram_clk,
    input  logic                   ram_rst,
    dcache_ram_responder_if.slave  ram
);
    localparam int BEAT_W = OFFSET_WIDTH - 2;
    localparam int LAT_W  = 16;
    localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;

    // Clears the in-line word bits so a burst always starts at the line base.
    localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK =
        ~(MEM_ADDR_WIDTH'((1 << BEAT_W) - 1));

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_RBURST  = 3'd2;
    localparam logic [2:0] S_RSINGLE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_TURN    = 3'd5;

    logic [31:0] mem [0:DEPTH-1];

    logic [2:0]                state;
    logic [MEM_ADDR_WIDTH-1:0] word_q;
    logic                      wr_q;
    logic                      unc_q;
    logic [3:0]                strb_q;
    logic [31:0]               wdata_q;
    logic [LAT_W-1:0]          lat_cnt;
    logic [BEAT_W-1:0]         beat;

    logic [MEM_ADDR_WIDTH-1:0] req_word;
    logic                      req_burst;
    logic [LAT_W-1:0]          lat_last;
    logic [MEM_ADDR_WIDTH-1:0] rd_word;
    logic                      beat_vld;

    // Address bits above the array and the byte offset are intentionally dropped (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ram.ram_addr[31:MEM_ADDR_WIDTH+2], ram.ram_addr[1:0]};

    assign req_burst = !ram.ram_wr && !ram.uncached;
    assign req_word  = req_burst ? (ram.ram_addr[MEM_ADDR_WIDTH+1:2] & LINE_MASK)
                                 : ram.ram_addr[MEM_ADDR_WIDTH+1:2];

    // lat_cnt is 0 in the addr_ok cycle, so the last WAIT cycle is latency-1.
    assign lat_last = wr_q ? LAT_W'(WRITE_LATENCY - 1) : LAT_W'(READ_LATENCY - 1);

    // Burst base has zero low bits and beat stays 0 outside bursts, so OR works for both read kinds.
    assign rd_word  = word_q | MEM_ADDR_WIDTH'(beat);
    assign beat_vld = (state == S_RBURST) || (state == S_RSINGLE);

    assign ram.ram_addr_ok = (state == S_WAIT) && (lat_cnt == '0);
    assign ram.ram_beat_ok = beat_vld;
    assign ram.ram_data_ok = (state == S_RSINGLE) || (state == S_WRITE) ||
                             ((state == S_RBURST) && (beat == '1));
    assign ram.ram_rdata   = beat_vld ? mem[rd_word] : 32'd0;

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            state   <= S_IDLE;
            word_q  <= '0;
            wr_q    <= 1'b0;
            unc_q   <= 1'b0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
            lat_cnt <= '0;
            beat    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ram.ram_req != 4'd0) begin
                        word_q  <= req_word;
                        wr_q    <= ram.ram_wr;
                        unc_q   <= ram.uncached;
                        strb_q  <= ram.ram_req;
                        wdata_q <= ram.ram_wdata;
                        lat_cnt <= '0;
                        beat    <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == lat_last) begin
                        lat_cnt <= '0;
                        if (wr_q)       state <= S_WRITE;
                        else if (unc_q) state <= S_RSINGLE;
                        else            state <= S_RBURST;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_RBURST: begin
                    // Hold at the last beat rather than incrementing, so it can never wrap.
                    if (beat == '1) state <= S_TURN;
                    else            beat  <= beat + BEAT_W'(1);
                end
                S_RSINGLE: state <= S_TURN;
                S_WRITE:   state <= S_TURN;
                S_TURN: begin
                    // Request is still high here while the cache drops it; never sample in TURN.
                    beat  <= '0;
                    state <= S_IDLE;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; a reset coinciding with the WRITE cycle discards the write.
    always_ff @(posedge ram_clk) begin
        if (!ram_rst && (state == S_WRITE)) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dcache_ram_responder.sv
`timescale 1ns/1ps
module tb_dcache_ram_responder;
    localparam int RL = 2;
    localparam int WL = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ram_responder_if ram ();

    dcache_ram_responder #(
        .MEM_ADDR_WIDTH (14),
        .OFFSET_WIDTH   (6),
        .READ_LATENCY   (RL),
        .WRITE_LATENCY  (WL),
        .INIT_FILE      ("")
    ) dut (
        .ram_clk (clk),
        .ram_rst (rst),
        .ram     (ram)
    );

    // Reference memory: word index -> contents, only for words the bench has written.
    logic [31:0] ref_mem [int];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // {addr_ok, beat_ok, data_ok, rdata}
    function automatic logic [34:0] outs();
        return {ram.ram_addr_ok, ram.ram_beat_ok, ram.ram_data_ok, ram.ram_rdata};
    endfunction

    task automatic drive(input logic [3:0] strb, input logic wr, input logic unc,
                         input logic [31:0] addr, input logic [31:0] wd);
        ram.ram_req   = strb;
        ram.ram_wr    = wr;
        ram.uncached  = unc;
        ram.ram_addr  = addr;
        ram.ram_wdata = wd;
    endtask

    // One complete transaction, checked cycle by cycle against the expected timeline.
    // abort_at: cycle offset after addr_ok at which reset is asserted (-1 = none).
    task automatic run_txn(input logic wr, input logic unc, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input bit scramble, input int abort_at, input bit release_rst);
        int n, first, last, idx, base;
        logic [34:0] exp;
        @(negedge clk);
        drive(strb, wr, unc, addr, wd);
        if (release_rst) rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ram.ram_addr_ok && n < 8);
        check("addr_ok_delay", n, 1);
        if (!ram.ram_addr_ok) begin
            ram.ram_req = 4'd0;
            return;
        end
        idx   = int'(addr[15:2]);
        base  = (!wr && !unc) ? (idx & ~15) : idx;
        first = wr ? WL : RL;
        last  = (!wr && !unc) ? first + 15 : first;
        if (scramble) begin
            ram.ram_addr  = $urandom;
            ram.ram_wr    = ~wr;
            ram.uncached  = ~unc;
            ram.ram_wdata = $urandom;
            ram.ram_req   = 4'($urandom_range(1, 15));
        end
        for (int i = 1; i <= last + 1; i++) begin
            @(negedge clk);
            exp = '0;
            if (i >= first && i <= last) begin
                if (wr) begin
                    exp[32] = 1'b1;
                end else begin
                    exp[33]   = 1'b1;
                    exp[31:0] = ref_mem[base + i - first];
                    if (i == last) exp[32] = 1'b1;
                end
            end
            check(wr ? "write_cycle" : (unc ? "single_cycle" : "burst_cycle"), outs(), exp);
            if (i == last && !scramble) ram.ram_req = 4'd0;
            if (i == abort_at) begin
                rst = 1'b1;
                ram.ram_req = 4'd0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("abort_quiet", outs(), 0);
                end
                rst = 1'b0;
                return;
            end
        end
        if (wr) begin
            if (!ref_mem.exists(idx)) ref_mem[idx] = 32'd0;
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
        if (scramble) begin
            // Request held through TURN must not have been accepted.
            @(negedge clk);
            check("turn_ignores_req", outs(), 0);
            ram.ram_req = 4'd0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] val;
        logic [31:0] a;
        int          w;
        int          kind;

        rst = 1'b1;
        drive(4'hF, 1'b0, 1'b1, 32'h0, 32'h0);

        // Reset with request held: outputs stay low; release with request dropped.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_quiet", outs(), 0);
        end
        rst = 1'b0;
        ram.ram_req = 4'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("no_req_after_reset", outs(), 0);
        end

        // Reset again, then release with the request still set: accepted right away.
        rst = 1'b1;
        drive(4'hF, 1'b1, 1'b0, 32'h0000_0500, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_quiet", outs(), 0);
        end
        run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0500, 32'hCAFE_F00D, 1'b0, -1, 1'b1);

        // Preload the working region through the write path.
        for (int wi = 'h100; wi < 'h140; wi++) begin
            if (wi == 'h100)                    val = 32'hDEAD_BEEF;
            else if (wi >= 'h110 && wi < 'h120) val = (wi - 'h110) * 32'h0101_0101;
            else                                val = $urandom;
            run_txn(1'b1, 1'b0, 4'hF, 32'(wi) << 2, val, 1'b0, -1, 1'b0);
        end
        run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0080, 32'h1122_3344, 1'b0, -1, 1'b0);

        // Aliased uncached read, burst refill, strobed write then read-back.
        run_txn(1'b0, 1'b1, 4'hF, 32'hA000_0400, 32'h0, 1'b0, -1, 1'b0);
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0448, 32'h0, 1'b0, -1, 1'b0);
        run_txn(1'b1, 1'b0, 4'b0110, 32'h0000_0080, 32'hAABB_CCDD, 1'b0, -1, 1'b0);
        run_txn(1'b0, 1'b1, 4'hF, 32'h0000_0080, 32'h0, 1'b0, -1, 1'b0);
        check("strobe_merge_read", ref_mem[32'h20], 32'h11BB_CC44);
        run_txn(1'b0, 1'b1, 4'hF, 32'h0000_0500, 32'h0, 1'b0, -1, 1'b0);

        // Reset during beat 5, then the same burst restarts at beat 0.
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b0, RL + 5, 1'b0);
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b0, -1, 1'b0);

        // Reset during the write cycle drops the write.
        run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0404, 32'h5555_AAAA, 1'b0, WL, 1'b0);
        run_txn(1'b0, 1'b1, 4'hF, 32'h0000_0404, 32'h0, 1'b0, -1, 1'b0);

        // Inputs change after acceptance and request stays high through TURN.
        run_txn(1'b1, 1'b0, 4'b1001, 32'h0000_04F0, 32'h1234_5678, 1'b1, -1, 1'b0);
        run_txn(1'b0, 1'b0, 4'hF, 32'h0000_04C0, 32'h0, 1'b1, -1, 1'b0);
        run_txn(1'b0, 1'b1, 4'h1, 32'h0000_04F0, 32'h0, 1'b1, -1, 1'b0);

        // Random mix over the preloaded region with random upper (aliased) and byte bits.
        for (int t = 0; t < 40; t++) begin
            w    = 'h100 + $urandom_range(0, 63);
            a    = ($urandom & 32'hFFFF_0000) | (32'(w) << 2) | ($urandom & 32'h3);
            kind = $urandom_range(0, 2);
            case (kind)
                0:       run_txn(1'b0, 1'b1, 4'($urandom_range(1, 15)), a, 32'h0,
                                 1'($urandom_range(0, 1)), -1, 1'b0);
                1:       run_txn(1'b0, 1'b0, 4'($urandom_range(1, 15)), a, 32'h0,
                                 1'($urandom_range(0, 1)), -1, 1'b0);
                default: run_txn(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a,
                                 $urandom, 1'($urandom_range(0, 1)), -1, 1'b0);
            endcase
        end

        @(negedge clk);
        check("idle_at_end", outs(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
